// File: rtl/int_svc.sv
// Interrupt service sequencer: detects a synchronized level interrupt, pulses a
// clear after a programmable delay, waits for release, then optionally steps the divider.
`timescale 1ns/1ps
module int_svc #(
  parameter int unsigned CLR_W  = 4,
  parameter int unsigned REL_TO = 32
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic        irq_i,
  input  logic [31:0] irq_cnt_i,
  input  logic        enable_i,
  input  logic [15:0] clr_dly_i,
  input  logic        div_seq_en_i,
  input  logic [11:0] div_step_i,
  output logic        int_clr_o,
  output logic [11:0] div_o,
  output logic        wren_o,
  output logic [31:0] svc_cnt_o,
  output logic [31:0] miss_cnt_o,
  output logic [15:0] lat_max_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned CLR_CW = (CLR_W > 1) ? $clog2(CLR_W) : 1;
  localparam int unsigned REL_CW = (REL_TO > 1) ? $clog2(REL_TO) : 1;
  localparam logic [CLR_CW-1:0] CLR_LAST = CLR_CW'(CLR_W - 1);
  localparam logic [REL_CW-1:0] REL_LAST = REL_CW'(REL_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_CLEAR   = 3'd2,
    S_RELEASE = 3'd3,
    S_UPDATE  = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_sync1;
  logic               r_irq_s;
  logic [31:0]        r_last_cnt;
  logic [15:0]        r_dly_cnt;
  logic [15:0]        r_lat_cnt;
  logic [CLR_CW-1:0]  r_clr_cnt;
  logic [REL_CW-1:0]  r_rel_cnt;
  logic               r_int_clr;
  logic [11:0]        r_div;
  logic               r_wren;
  logic [31:0]        r_svc_cnt;
  logic [31:0]        r_miss_cnt;
  logic [15:0]        r_lat_max;
  logic               r_busy;
  logic               r_err;

  // Events skipped since the last serviced one, saturating at all-ones
  logic [31:0] w_delta;
  logic [32:0] w_miss_sum;
  logic [31:0] w_miss_next;

  assign w_delta     = irq_cnt_i - r_last_cnt;
  assign w_miss_sum  = {1'b0, r_miss_cnt} + {1'b0, w_delta - 32'd1};
  assign w_miss_next = (w_delta > 32'd1) ? (w_miss_sum[32] ? 32'hFFFF_FFFF : w_miss_sum[31:0])
                                         : r_miss_cnt;

  always_ff @(posedge clk100) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b0;
      r_irq_s    <= 1'b0;
      r_last_cnt <= 32'd0;
      r_dly_cnt  <= 16'd0;
      r_lat_cnt  <= 16'd0;
      r_clr_cnt  <= '0;
      r_rel_cnt  <= '0;
      r_int_clr  <= 1'b0;
      r_div      <= 12'd0;
      r_wren     <= 1'b0;
      r_svc_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
      r_lat_max  <= 16'd0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_sync1 <= irq_i;
      r_irq_s <= r_sync1;
      r_wren  <= 1'b0;
      // Latency runs through WAIT, CLEAR and RELEASE
      if ((r_state inside {S_WAIT, S_CLEAR, S_RELEASE}) && (r_lat_cnt != 16'hFFFF))
        r_lat_cnt <= r_lat_cnt + 16'd1;

      case (r_state)
        S_IDLE: begin
          if (enable_i && r_irq_s) begin
            r_state    <= S_WAIT;
            r_busy     <= 1'b1;
            r_dly_cnt  <= 16'd0;
            r_lat_cnt  <= 16'd0;
            r_miss_cnt <= w_miss_next;
            r_last_cnt <= irq_cnt_i;
          end
        end
        S_WAIT: begin
          if (r_dly_cnt == clr_dly_i) begin
            r_state   <= S_CLEAR;
            r_int_clr <= 1'b1;
            r_clr_cnt <= '0;
          end else begin
            r_dly_cnt <= r_dly_cnt + 16'd1;
          end
        end
        S_CLEAR: begin
          if (r_clr_cnt == CLR_LAST) begin
            r_state   <= S_RELEASE;
            r_int_clr <= 1'b0;
            r_rel_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + CLR_CW'(1);
          end
        end
        S_RELEASE: begin
          if (!r_irq_s) begin
            // Divider write is registered on entry so wren_o coincides with UPDATE
            r_state   <= S_UPDATE;
            r_svc_cnt <= r_svc_cnt + 32'd1;
            if (r_lat_cnt > r_lat_max) r_lat_max <= r_lat_cnt;
            if (div_seq_en_i) begin
              r_div  <= r_div + div_step_i;
              r_wren <= 1'b1;
            end
          end else if (r_rel_cnt == REL_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_rel_cnt <= r_rel_cnt + REL_CW'(1);
          end
        end
        S_UPDATE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_int_clr <= 1'b0;
        end
      endcase
    end
  end

  assign int_clr_o  = r_int_clr;
  assign div_o      = r_div;
  assign wren_o     = r_wren;
  assign svc_cnt_o  = r_svc_cnt;
  assign miss_cnt_o = r_miss_cnt;
  assign lat_max_o  = r_lat_max;
  assign busy_o     = r_busy;
  assign err_o      = r_err;

endmodule

// File: tb/tb_int_svc.sv
// Self-checking bench for int_svc: directed service sequences with a divider-write
// scoreboard and a small model of the miss/service counters.
`timescale 1ns/1ps
module tb_int_svc;

  localparam int unsigned CLR_W  = 4;
  localparam int unsigned REL_TO = 32;

  logic        clk100 = 1'b0;
  logic        rst;
  logic        irq_i;
  logic [31:0] irq_cnt_i;
  logic        enable_i;
  logic [15:0] clr_dly_i;
  logic        div_seq_en_i;
  logic [11:0] div_step_i;
  logic        int_clr_o;
  logic [11:0] div_o;
  logic        wren_o;
  logic [31:0] svc_cnt_o;
  logic [31:0] miss_cnt_o;
  logic [15:0] lat_max_o;
  logic        busy_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_wren   = 0;

  logic [11:0] sb_q[$];
  logic [11:0] exp_div;
  logic        prev_wren = 1'b0;
  logic [31:0] m_last, m_miss, m_svc;
  logic [11:0] m_div;

  int_svc #(.CLR_W(CLR_W), .REL_TO(REL_TO)) dut (
    .clk100(clk100), .rst(rst), .irq_i(irq_i), .irq_cnt_i(irq_cnt_i),
    .enable_i(enable_i), .clr_dly_i(clr_dly_i), .div_seq_en_i(div_seq_en_i),
    .div_step_i(div_step_i), .int_clr_o(int_clr_o), .div_o(div_o), .wren_o(wren_o),
    .svc_cnt_o(svc_cnt_o), .miss_cnt_o(miss_cnt_o), .lat_max_o(lat_max_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk100 = ~clk100;

  // Divider write monitor: each strobe pops the next expected divider value
  always @(negedge clk100) begin
    if (wren_o) begin
      n_wren++;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL wren_unexpected: div_o=%h with no write expected", div_o);
      end else begin
        exp_div = sb_q.pop_front();
        if (div_o !== exp_div) begin
          n_errors++;
          $display("FAIL div_write: div_o=%h expected %h", div_o, exp_div);
        end
      end
      n_checks++;
      if (prev_wren || int_clr_o) begin
        n_errors++;
        $display("FAIL wren_shape: prev_wren=%b int_clr_o=%b expected 0 0", prev_wren, int_clr_o);
      end
    end
    prev_wren = wren_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  function automatic void model_entry();
    logic [31:0] d;
    logic [32:0] s;
    d = irq_cnt_i - m_last;
    if (d > 32'd1) begin
      s = {1'b0, m_miss} + {1'b0, d - 32'd1};
      m_miss = s[32] ? 32'hFFFF_FFFF : s[31:0];
    end
    m_last = irq_cnt_i;
  endfunction

  function automatic void model_reset();
    m_last = 32'd0;
    m_miss = 32'd0;
    m_svc  = 32'd0;
    m_div  = 12'd0;
    sb_q.delete();
  endfunction

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy_o && c < 500) begin
      tick(1);
      c++;
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_idle_timeout: busy_o=%b expected 0", name, busy_o);
    end
  endtask

  // One complete service; irq_i drops `hold` cycles after int_clr_o falls
  task automatic service(input int hold);
    int c;
    int w;
    model_entry();
    m_svc++;
    if (div_seq_en_i) begin
      m_div = m_div + div_step_i;
      sb_q.push_back(m_div);
    end
    irq_i = 1'b1;
    c = 0;
    do begin tick(1); c++; end while (!int_clr_o && c < 300);
    n_checks++;
    if (c != 4 + int'(clr_dly_i)) begin
      n_errors++;
      $display("FAIL clr_start: int_clr_o rose after %0d cycles expected %0d", c, 4 + int'(clr_dly_i));
    end
    w = 0;
    while (int_clr_o && w < 100) begin tick(1); w++; end
    n_checks++;
    if (w != int'(CLR_W)) begin
      n_errors++;
      $display("FAIL clr_width: %0d cycles expected %0d", w, CLR_W);
    end
    if (hold > 0) tick(hold);
    irq_i = 1'b0;
    wait_idle("service");
    n_checks++;
    if (svc_cnt_o !== m_svc) begin
      n_errors++;
      $display("FAIL svc_cnt: %0d expected %0d", svc_cnt_o, m_svc);
    end
    n_checks++;
    if (miss_cnt_o !== m_miss) begin
      n_errors++;
      $display("FAIL miss_cnt: %h expected %h", miss_cnt_o, m_miss);
    end
  endtask

  task automatic test_reset();
    irq_i = 1'b0; irq_cnt_i = 32'd0; enable_i = 1'b1; clr_dly_i = 16'd0;
    div_seq_en_i = 1'b0; div_step_i = 12'd0;
    rst = 1'b1;
    tick(3);
    n_checks++;
    if ({int_clr_o, wren_o, busy_o, err_o} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: clr/wren/busy/err=%b expected 0000", {int_clr_o, wren_o, busy_o, err_o});
    end
    n_checks++;
    if ({div_o, svc_cnt_o, miss_cnt_o, lat_max_o} !== 92'd0) begin
      n_errors++;
      $display("FAIL reset_counters: div=%h svc=%h miss=%h lat=%h expected 0", div_o, svc_cnt_o, miss_cnt_o, lat_max_o);
    end
    rst = 1'b0;
    model_reset();
    tick(2);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: busy_o=%b expected 0", busy_o);
    end
  endtask

  task automatic test_basic();
    int w0;
    w0 = n_wren;
    clr_dly_i = 16'd10;
    irq_cnt_i = 32'd1;
    service(3);
    // 11 WAIT + 4 CLEAR + 5 RELEASE cycles before the release is seen
    n_checks++;
    if (lat_max_o !== 16'd20) begin
      n_errors++;
      $display("FAIL basic_lat_max: %0d expected 20", lat_max_o);
    end
    n_checks++;
    if (n_wren - w0 != 0) begin
      n_errors++;
      $display("FAIL basic_no_wren: %0d pulses expected 0", n_wren - w0);
    end
  endtask

  task automatic test_div_step();
    int w0;
    w0 = n_wren;
    div_seq_en_i = 1'b1;
    div_step_i   = 12'h010;
    clr_dly_i    = 16'd3;
    for (int i = 0; i < 3; i++) begin
      irq_cnt_i = irq_cnt_i + 32'd1;
      service(1);
    end
    n_checks++;
    if (div_o !== 12'h030) begin
      n_errors++;
      $display("FAIL div_step_value: %h expected 030", div_o);
    end
    n_checks++;
    if (n_wren - w0 != 3) begin
      n_errors++;
      $display("FAIL div_step_pulses: %0d expected 3", n_wren - w0);
    end
  endtask

  task automatic test_wrap();
    div_step_i = 12'hFC8;
    irq_cnt_i  = irq_cnt_i + 32'd1;
    service(0);
    n_checks++;
    if (div_o !== 12'hFF8) begin
      n_errors++;
      $display("FAIL wrap_setup: %h expected ff8", div_o);
    end
    div_step_i = 12'h010;
    irq_cnt_i  = irq_cnt_i + 32'd1;
    service(2);
    n_checks++;
    if (div_o !== 12'h008) begin
      n_errors++;
      $display("FAIL wrap_value: %h expected 008", div_o);
    end
  endtask

  task automatic test_miss();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(1);
    div_seq_en_i = 1'b0;
    clr_dly_i    = 16'd0;
    irq_cnt_i    = 32'd1;
    service(1);
    irq_cnt_i = 32'd5;
    service(1);
    n_checks++;
    if (miss_cnt_o !== 32'd3) begin
      n_errors++;
      $display("FAIL miss_jump: %0d expected 3", miss_cnt_o);
    end
    irq_cnt_i = irq_cnt_i + 32'h8000_0000;
    service(0);
    irq_cnt_i = irq_cnt_i + 32'h8000_0000;
    service(0);
    n_checks++;
    if (miss_cnt_o !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL miss_saturate: %h expected ffffffff", miss_cnt_o);
    end
  endtask

  task automatic test_stuck_irq();
    int c;
    logic [31:0] svc0;
    clr_dly_i = 16'd2;
    svc0 = m_svc;
    model_entry();
    irq_i = 1'b1;
    c = 0;
    do begin tick(1); c++; end while (!int_clr_o && c < 300);
    c = 0;
    do begin tick(1); c++; end while (int_clr_o && c < 100);
    c = 0;
    do begin tick(1); c++; end while (!err_o && c < 100);
    n_checks++;
    if (c != int'(REL_TO)) begin
      n_errors++;
      $display("FAIL stuck_err_time: err_o after %0d release cycles expected %0d", c, REL_TO);
    end
    n_checks++;
    if (svc_cnt_o !== svc0) begin
      n_errors++;
      $display("FAIL stuck_svc: %0d expected %0d", svc_cnt_o, svc0);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL stuck_idle: busy_o=%b expected 0", busy_o);
    end
    tick(1);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_errors++;
      $display("FAIL stuck_restart: busy_o=%b expected 1", busy_o);
    end
    model_entry();
    m_svc++;
    irq_i = 1'b0;
    wait_idle("stuck");
    n_checks++;
    if (svc_cnt_o !== m_svc) begin
      n_errors++;
      $display("FAIL stuck_resume_svc: %0d expected %0d", svc_cnt_o, m_svc);
    end
    n_checks++;
    if (err_o !== 1'b1) begin
      n_errors++;
      $display("FAIL stuck_err_sticky: err_o=%b expected 1", err_o);
    end
  endtask

  task automatic test_enable();
    int c;
    enable_i = 1'b0;
    irq_i    = 1'b1;
    tick(10);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL enable_gate: busy_o=%b expected 0", busy_o);
    end
    model_entry();
    m_svc++;
    enable_i = 1'b1;
    c = 0;
    do begin tick(1); c++; end while (!int_clr_o && c < 300);
    enable_i = 1'b0;
    c = 0;
    do begin tick(1); c++; end while (int_clr_o && c < 100);
    irq_i = 1'b0;
    wait_idle("enable");
    n_checks++;
    if (svc_cnt_o !== m_svc) begin
      n_errors++;
      $display("FAIL enable_complete: svc=%0d expected %0d", svc_cnt_o, m_svc);
    end
    enable_i = 1'b1;
  endtask

  task automatic test_reset_mid_clear();
    int c;
    clr_dly_i = 16'd1;
    irq_i     = 1'b1;
    c = 0;
    do begin tick(1); c++; end while (!int_clr_o && c < 300);
    tick(1);
    n_checks++;
    if (int_clr_o !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_clear_setup: int_clr_o=%b expected 1", int_clr_o);
    end
    rst   = 1'b1;
    irq_i = 1'b0;
    tick(1);
    n_checks++;
    if ({int_clr_o, busy_o, err_o, wren_o} !== 4'b0000) begin
      n_errors++;
      $display("FAIL rst_clear_flags: clr/busy/err/wren=%b expected 0000", {int_clr_o, busy_o, err_o, wren_o});
    end
    n_checks++;
    if ({div_o, svc_cnt_o, miss_cnt_o, lat_max_o} !== 92'd0) begin
      n_errors++;
      $display("FAIL rst_clear_counters: div=%h svc=%h miss=%h lat=%h expected 0", div_o, svc_cnt_o, miss_cnt_o, lat_max_o);
    end
    rst = 1'b0;
    model_reset();
    tick(3);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_clear_idle: busy_o=%b expected 0", busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_step();
    test_wrap();
    test_miss();
    test_stuck_irq();
    test_enable();
    test_reset_mid_clear();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: %0d expected writes missing", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
